// File: rtl/booth_multiplier_pipe_param.sv
// Fully pipelined radix-2 Booth multiplier: one Booth step per stage, WIDTH+1 stages,
// per-sample signed/unsigned mode, valid/tag tracking and a global advance enable.
module booth_multiplier_pipe_param #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int N  = WIDTH + 1;
    localparam int PW = 2 * N + 1;

    // One extra operand bit lets signed and unsigned samples share the same signed Booth core.
    logic [N-1:0] w_a_ext;
    logic [N-1:0] w_b_ext;

    assign w_a_ext = sgn ? {a[WIDTH-1], a} : {1'b0, a};
    assign w_b_ext = sgn ? {b[WIDTH-1], b} : {1'b0, b};

    for (genvar gi = 1; gi <= N; gi++) begin : g_stage
        logic [PW-1:0]    w_p_in;
        logic [N-1:0]     w_m_in;
        logic [N-1:0]     w_mn_in;
        logic             w_v_in;
        logic [TAG_W-1:0] w_tag_in;
        logic [N-1:0]     w_upper;
        logic [PW-1:0]    w_p_next;

        logic [PW-1:0]    r_p;
        logic [N-1:0]     r_m;
        logic [N-1:0]     r_mn;
        logic             r_v;
        logic [TAG_W-1:0] r_tag;

        if (gi == 1) begin : g_seed
            assign w_p_in   = {{N{1'b0}}, w_b_ext, 1'b0};
            assign w_m_in   = w_a_ext;
            assign w_mn_in  = ~w_a_ext + N'(1);
            assign w_v_in   = in_valid;
            assign w_tag_in = in_tag;
        end else begin : g_chain
            assign w_p_in   = g_stage[gi-1].r_p;
            assign w_m_in   = g_stage[gi-1].r_m;
            assign w_mn_in  = g_stage[gi-1].r_mn;
            assign w_v_in   = g_stage[gi-1].r_v;
            assign w_tag_in = g_stage[gi-1].r_tag;
        end

        always_comb begin
            w_upper = w_p_in[PW-1:N+1];
            case (w_p_in[1:0])
                2'b01:   w_upper = w_upper + w_m_in;
                2'b10:   w_upper = w_upper + w_mn_in;
                default: w_upper = w_p_in[PW-1:N+1];
            endcase
            // Arithmetic shift right of {upper, lower} by one, keeping the sign of the upper field.
            w_p_next = {w_upper[N-1], w_upper, w_p_in[N:1]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_p   <= '0;
                r_m   <= '0;
                r_mn  <= '0;
                r_v   <= 1'b0;
                r_tag <= '0;
            end else if (ce) begin
                r_p   <= w_p_next;
                r_m   <= w_m_in;
                r_mn  <= w_mn_in;
                r_v   <= w_v_in;
                r_tag <= w_tag_in;
            end
        end
    end

    // The 2N-bit Booth result sits in P[2N:1]; its low 2*WIDTH bits are exact in both modes.
    assign product   = g_stage[N].r_p[2*WIDTH:1];
    assign out_valid = g_stage[N].r_v;
    assign out_tag   = g_stage[N].r_tag;

endmodule

// File: tb/tb_booth_multiplier_pipe_param.sv
// Directed-vector bench for booth_multiplier_pipe_param: WIDTH=8 stream/bubble/stall/reset
// sequences against a latency scoreboard, plus a WIDTH=2/16/32 corner-operand sweep.
module tb_booth_multiplier_pipe_param;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int N  = W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, ce, in_valid, sgn;
    logic [W-1:0]    a, b;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   out_tag;

    booth_multiplier_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sgn(sgn), .a(a), .b(b),
        .in_tag(in_tag), .out_valid(out_valid), .product(product), .out_tag(out_tag)
    );

    // Width-sweep instances share clk/rst/ce with the main DUT.
    logic        v2, s2, ov2;     logic [1:0]  a2, b2;   logic [3:0]  p2;  logic [3:0] t2, ot2;
    logic        v16, s16, ov16;  logic [15:0] a16, b16; logic [31:0] p16; logic [3:0] t16, ot16;
    logic        v32, s32, ov32;  logic [31:0] a32, b32; logic [63:0] p32; logic [3:0] t32, ot32;

    booth_multiplier_pipe_param #(.WIDTH(2), .TAG_W(4)) u_w2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v2), .sgn(s2), .a(a2), .b(b2),
        .in_tag(t2), .out_valid(ov2), .product(p2), .out_tag(ot2));
    booth_multiplier_pipe_param #(.WIDTH(16), .TAG_W(4)) u_w16 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v16), .sgn(s16), .a(a16), .b(b16),
        .in_tag(t16), .out_valid(ov16), .product(p16), .out_tag(ot16));
    booth_multiplier_pipe_param #(.WIDTH(32), .TAG_W(4)) u_w32 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v32), .sgn(s32), .a(a32), .b(b32),
        .in_tag(t32), .out_valid(ov32), .product(p32), .out_tag(ot32));

    typedef struct {
        logic           s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [20];

    int errors = 0;
    int checks = 0;

    // Expected contents of each stage (valid, product, tag) as seen at the output N stages later.
    logic           ev [1:N];
    logic [2*W-1:0] ep [1:N];
    logic [TW-1:0]  et [1:N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic v, input int idx,
                       input logic [TW-1:0] tg);
        rst = r; ce = c; in_valid = v;
        sgn = vecs[idx].s; a = vecs[idx].a; b = vecs[idx].b; in_tag = tg;
        @(posedge clk); #1;
        if (r) begin
            for (int k = 1; k <= N; k++) begin ev[k] = 1'b0; ep[k] = '0; et[k] = '0; end
        end else if (c) begin
            for (int k = N; k > 1; k--) begin ev[k] = ev[k-1]; ep[k] = ep[k-1]; et[k] = et[k-1]; end
            ev[1] = v; ep[1] = vecs[idx].p; et[1] = tg;
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, ev[N]});
        if (ev[N]) begin
            chk("product", {48'd0, product}, {48'd0, ep[N]});
            chk("out_tag", {60'd0, out_tag}, {60'd0, et[N]});
            $display("out tag=%0d product=%04h", out_tag, product);
        end
    endtask

    logic [1:0]  sw_a2  [3];  logic [1:0]  sw_b2  [3];  logic [3:0]  sw_p2  [3];
    logic [15:0] sw_a16 [3];  logic [15:0] sw_b16 [3];  logic [31:0] sw_p16 [3];
    logic [31:0] sw_a32 [3];  logic [31:0] sw_b32 [3];  logic [63:0] sw_p32 [3];
    logic        sw_s   [3];

    initial begin
        vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[3]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vecs[4]  = '{1'b1, 8'h00, 8'h7F, 16'h0000};
        vecs[5]  = '{1'b1, 8'h7F, 8'h81, 16'hC0FF};
        vecs[6]  = '{1'b0, 8'h03, 8'h05, 16'h000F};
        vecs[7]  = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
        vecs[8]  = '{1'b0, 8'hFE, 8'h03, 16'h02FA};
        vecs[9]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[10] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
        vecs[11] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[12] = '{1'b0, 8'h10, 8'h10, 16'h0100};
        vecs[13] = '{1'b1, 8'hF0, 8'h10, 16'hFF00};
        vecs[14] = '{1'b0, 8'hF0, 8'h10, 16'h0F00};
        vecs[15] = '{1'b1, 8'h81, 8'h81, 16'h3F01};
        vecs[16] = '{1'b0, 8'h81, 8'h81, 16'h4101};
        vecs[17] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[18] = '{1'b0, 8'hAA, 8'h02, 16'h0154};
        vecs[19] = '{1'b1, 8'hAA, 8'h02, 16'hFF54};

        // Sweep: signed min*min, unsigned max*max, zero*max.
        sw_s[0] = 1'b1; sw_s[1] = 1'b0; sw_s[2] = 1'b0;
        sw_a2[0] = 2'b10; sw_b2[0] = 2'b10; sw_p2[0] = 4'h4;
        sw_a2[1] = 2'b11; sw_b2[1] = 2'b11; sw_p2[1] = 4'h9;
        sw_a2[2] = 2'b00; sw_b2[2] = 2'b11; sw_p2[2] = 4'h0;
        sw_a16[0] = 16'h8000; sw_b16[0] = 16'h8000; sw_p16[0] = 32'h4000_0000;
        sw_a16[1] = 16'hFFFF; sw_b16[1] = 16'hFFFF; sw_p16[1] = 32'hFFFE_0001;
        sw_a16[2] = 16'h0000; sw_b16[2] = 16'hFFFF; sw_p16[2] = 32'h0;
        sw_a32[0] = 32'h8000_0000; sw_b32[0] = 32'h8000_0000; sw_p32[0] = 64'h4000_0000_0000_0000;
        sw_a32[1] = 32'hFFFF_FFFF; sw_b32[1] = 32'hFFFF_FFFF; sw_p32[1] = 64'hFFFF_FFFE_0000_0001;
        sw_a32[2] = 32'h0000_0000; sw_b32[2] = 32'hFFFF_FFFF; sw_p32[2] = 64'h0;

        v2 = 0; s2 = 0; a2 = 0; b2 = 0; t2 = 0;
        v16 = 0; s16 = 0; a16 = 0; b16 = 0; t16 = 0;
        v32 = 0; s32 = 0; a32 = 0; b32 = 0; t32 = 0;

        // Reset state
        cyc(1'b1, 1'b1, 1'b0, 0, 4'd0);
        cyc(1'b1, 1'b1, 1'b0, 0, 4'd0);
        chk("reset_product", {48'd0, product}, 64'd0);
        chk("reset_tag", {60'd0, out_tag}, 64'd0);

        // Back-to-back stream of all 20 vectors, tags 0..19 (tag width wraps at 16)
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, i, TW'(i));
        for (int i = 0; i < N + 2; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);

        // Bubble pattern: valid, bubble, valid
        cyc(1'b0, 1'b1, 1'b1, 6, 4'hA);
        cyc(1'b0, 1'b1, 1'b0, 1, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 7, 4'hB);
        for (int i = 0; i < N + 1; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);

        // Stall on the input side (in_valid ignored while ce=0), then while outputs stream
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8 + i, TW'(1 + i));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 0, 4'hF);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 12 + i, TW'(5 + i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, 4'd0);
        for (int i = 0; i < N + 2; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);

        // Reset mid-operation discards in-flight samples
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 14 + i, TW'(8 + i));
        cyc(1'b1, 1'b1, 1'b0, 0, 4'd0);
        chk("midreset_product", {48'd0, product}, 64'd0);
        chk("midreset_tag", {60'd0, out_tag}, 64'd0);
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 6, 4'h3);
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 1'b0, 0, 4'd0);

        // Width sweep: three samples back to back into each width, latency WIDTH+1
        rst = 1'b0; ce = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 36; c++) begin
            int k2, k16, k32;
            if (c < 3) begin
                v2 = 1; s2 = sw_s[c]; a2 = sw_a2[c]; b2 = sw_b2[c]; t2 = 4'(c);
                v16 = 1; s16 = sw_s[c]; a16 = sw_a16[c]; b16 = sw_b16[c]; t16 = 4'(c);
                v32 = 1; s32 = sw_s[c]; a32 = sw_a32[c]; b32 = sw_b32[c]; t32 = 4'(c);
            end else begin
                v2 = 0; v16 = 0; v32 = 0;
            end
            @(posedge clk); #1;
            k2 = c - 2; k16 = c - 16; k32 = c - 32;
            chk("w2_valid", {63'd0, ov2}, {63'd0, (k2 >= 0 && k2 < 3)});
            chk("w16_valid", {63'd0, ov16}, {63'd0, (k16 >= 0 && k16 < 3)});
            chk("w32_valid", {63'd0, ov32}, {63'd0, (k32 >= 0 && k32 < 3)});
            if (k2 >= 0 && k2 < 3) begin
                chk("w2_product", {60'd0, p2}, {60'd0, sw_p2[k2]});
                chk("w2_tag", {60'd0, ot2}, 64'(k2));
                $display("w2 tag=%0d product=%0h", ot2, p2);
            end
            if (k16 >= 0 && k16 < 3) begin
                chk("w16_product", {32'd0, p16}, {32'd0, sw_p16[k16]});
                chk("w16_tag", {60'd0, ot16}, 64'(k16));
                $display("w16 tag=%0d product=%0h", ot16, p16);
            end
            if (k32 >= 0 && k32 < 3) begin
                chk("w32_product", p32, sw_p32[k32]);
                chk("w32_tag", {60'd0, ot32}, 64'(k32));
                $display("w32 tag=%0d product=%0h", ot32, p32);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
